skin_threshold_stream: RTL and testbench
========================================

// Module: skin_threshold_stream
// PURPOSE
//  Streaming, pipelined YCbCr skin classifier for the skin_color_segm path: per-pixel Cb/Cr window test -> binary mask.
//  Thresholds are runtime-loadable into shadow registers and applied only at frame start, so a frame is never split.
//  Also counts skin pixels per frame for the downstream hand-detect/centroid logic.
//  Sits between the RGB->YCbCr converter and the morphology/centroid stages.
// PARAMETERS
//  DATA_W     8      component width of Y/Cb/Cr and thresholds
//  MASK_W     8      output mask width; skin = all ones, non-skin = 0
//  CNT_W      20     per-frame skin-pixel counter width; must hold 640*480
//  INCLUSIVE  0      0: strict lo<x<hi; 1: lo<=x<=hi
//  TA_DEF     77     reset Cb low bound
//  TB_DEF     127    reset Cb high bound
//  TC_DEF     133    reset Cr low bound
//  TD_DEF     173    reset Cr high bound
// PORTS
//  clk          in   1        single clock; all logic on rising edge
//  rst          in   1        synchronous, active-high reset
//  in_valid     in   1        pixel beat valid; no backpressure
//  in_sof       in   1        first pixel of frame; qualified by in_valid
//  in_y         in   DATA_W   luma
//  in_cb        in   DATA_W   blue-difference chroma
//  in_cr        in   DATA_W   red-difference chroma
//  thr_wr       in   1        load thr_* into shadow registers
//  thr_ta..td   in   DATA_W   Cb lo, Cb hi, Cr lo, Cr hi
//  out_valid    out  1        mask beat valid
//  out_sof      out  1        in_sof delayed with the mask
//  out_mask     out  MASK_W   binary skin mask
//  frame_cnt    out  CNT_W    skin-pixel count of the last completed frame
//  cnt_valid    out  1        one-cycle pulse when frame_cnt updates
// BEHAVIOUR
//  Reset: out_valid/out_sof/cnt_valid = 0, out_mask = 0, frame_cnt = 0, running count = 0.
//   Shadow and active thresholds = *_DEF. Reset mid-frame drops all in-flight beats.
//  Pipeline: fixed 2-cycle latency; valid and sof travel with data.
//   S1 registers the four compares. S2 registers the AND -> out_mask.
//   Bubbles propagate as out_valid = 0; out_mask holds its last value when out_valid = 0.
//  Threshold update:
//   - thr_wr writes the shadow registers.
//   - On an in_valid & in_sof beat, active <= shadow, and the new values are used for that beat.
//   - If thr_wr coincides with that beat, the thr_* values being written are used directly.
//   - Otherwise active thresholds stay constant for the whole frame.
//  Degenerate window: lo >= hi (strict) or lo > hi (inclusive) gives mask = 0 for the frame; this is not an error.
//  Counter, updated on S2 out_valid beats:
//   - A skin beat increments the running count; it saturates at all ones and never wraps.
//   - An out_sof beat latches the running count (previous frame) into frame_cnt and pulses cnt_valid.
//     The running count then restarts at 1 if this beat is skin, else 0.
//   - The first sof after reset also pulses, with frame_cnt = 0.
//  Compares are unsigned, DATA_W wide; no arithmetic growth.
// CONFIGURATION
//  SKIN_Y_GATE_EN defined:
//   - adds ports thr_ylo, thr_yhi (in, DATA_W), shadowed/applied like thr_*; reset values 0 and all ones;
//   - the mask additionally requires the Y window (same INCLUSIVE rule);
//   - latency is unchanged.
//  SKIN_Y_GATE_EN undefined: ports absent; in_y is ignored, registered only to keep the bus aligned.
// STRUCTURE
//  skin_segm_pkg.vh: default threshold constants, MASK_ON/MASK_OFF, INCLUSIVE encodings.
//  Sub-module skin_range_cmp (DATA_W, INCLUSIVE): x, lo, hi -> in_range, combinational.
//   Instantiated 2x, or 3x with SKIN_Y_GATE_EN.
//  Top level: shadow/active registers, 2-stage pipe, counter.
// TESTING
//  1 Reset defaults, INCLUSIVE=0: sof + (Cb,Cr) = (100,150), (77,150), (127,150), (100,173), (100,174)
//    -> masks FF,00,00,00,00 at cycles +2..+6.
//  2 INCLUSIVE=1, same stimulus -> FF,FF,FF,FF,00.
//  3 thr_wr Cb=[10,20] mid-frame: old window holds until next sof; at next sof (Cb,Cr)=(15,150) -> FF.
//    Repeat with thr_wr on the same cycle as sof -> FF on that beat.
//  4 Frame of 12 beats with 5 skin, random in_valid gaps, then sof
//    -> cnt_valid pulse with frame_cnt = 5; gaps produce no out_valid.
//  5 CNT_W=3, 10 skin beats then sof -> frame_cnt = 7 (saturated).
//    rst asserted mid-frame -> all outputs 0 the next cycle.
//  6 SKIN_Y_GATE_EN, Y window [50,200]: Y = 30 with skin chroma -> 00; Y = 100 -> FF.

Source files
------------

// File: rtl/skin_threshold_stream_pkg.sv
// Shared constants for the skin-segmentation threshold stage.
// Holds the default Cb/Cr window, the mask polarity and the compare-mode encodings.
package skin_threshold_stream_pkg;
  localparam int CMP_STRICT    = 0;
  localparam int CMP_INCLUSIVE = 1;

  localparam int TA_DEFAULT = 77;
  localparam int TB_DEFAULT = 127;
  localparam int TC_DEFAULT = 133;
  localparam int TD_DEFAULT = 173;

  localparam logic MASK_ON  = 1'b1;
  localparam logic MASK_OFF = 1'b0;
endpackage

// File: rtl/skin_range_cmp.sv
// Combinational unsigned window test of one colour component against [lo, hi].
// Operates in strict or inclusive mode; a degenerate window simply never matches.
module skin_range_cmp
  import skin_threshold_stream_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int INCLUSIVE = CMP_STRICT
) (
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] lo,
  input  logic [DATA_W-1:0] hi,
  output logic              in_range
);
  always_comb begin
    if (INCLUSIVE == CMP_INCLUSIVE) in_range = (x >= lo) && (x <= hi);
    else                            in_range = (x > lo) && (x < hi);
  end
endmodule

// File: rtl/skin_threshold_stream.sv
// Streaming YCbCr skin classifier: frame-aligned thresholds, 2-cycle mask pipe, per-frame skin count.
// Optional luma gate enabled by defining SKIN_Y_GATE_EN (adds thr_ylo/thr_yhi ports).
module skin_threshold_stream
  import skin_threshold_stream_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MASK_W    = 8,
  parameter int CNT_W     = 20,
  parameter int INCLUSIVE = CMP_STRICT,
  parameter int TA_DEF    = TA_DEFAULT,
  parameter int TB_DEF    = TB_DEFAULT,
  parameter int TC_DEF    = TC_DEFAULT,
  parameter int TD_DEF    = TD_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [DATA_W-1:0] in_y,
  input  logic [DATA_W-1:0] in_cb,
  input  logic [DATA_W-1:0] in_cr,
  input  logic              thr_wr,
  input  logic [DATA_W-1:0] thr_ta,
  input  logic [DATA_W-1:0] thr_tb,
  input  logic [DATA_W-1:0] thr_tc,
  input  logic [DATA_W-1:0] thr_td,
`ifdef SKIN_Y_GATE_EN
  input  logic [DATA_W-1:0] thr_ylo,
  input  logic [DATA_W-1:0] thr_yhi,
`endif
  output logic              out_valid,
  output logic              out_sof,
  output logic [MASK_W-1:0] out_mask,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic              cnt_valid
);
`ifdef SKIN_Y_GATE_EN
  localparam int NTHR = 6;
  localparam logic [NTHR-1:0][DATA_W-1:0] THR_RST = {{DATA_W{1'b1}}, {DATA_W{1'b0}},
    DATA_W'(TD_DEF), DATA_W'(TC_DEF), DATA_W'(TB_DEF), DATA_W'(TA_DEF)};
`else
  localparam int NTHR = 4;
  localparam logic [NTHR-1:0][DATA_W-1:0] THR_RST = {
    DATA_W'(TD_DEF), DATA_W'(TC_DEF), DATA_W'(TB_DEF), DATA_W'(TA_DEF)};
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [NTHR-1:0][DATA_W-1:0] thr_in, thr_eff;
  logic [NTHR-1:0][DATA_W-1:0] shadow_q, shadow_d, active_q, active_d;
  logic cb_in_range, cr_in_range;
  logic vld_p1_q, vld_p1_d, sof_p1_q, sof_p1_d;
  logic cb_ok_p1_q, cb_ok_p1_d, cr_ok_p1_q, cr_ok_p1_d;
  logic skin_p1;
  logic vld_p2_q, vld_p2_d, sof_p2_q, sof_p2_d;
  logic [MASK_W-1:0] mask_p2_q, mask_p2_d;
  logic [CNT_W-1:0]  run_cnt_q, run_cnt_d, frame_cnt_q, frame_cnt_d;
  logic              cnt_vld_q, cnt_vld_d;

`ifdef SKIN_Y_GATE_EN
  logic y_in_range, y_ok_p1_q, y_ok_p1_d;
  assign thr_in = {thr_yhi, thr_ylo, thr_td, thr_tc, thr_tb, thr_ta};

  skin_range_cmp #(.DATA_W(DATA_W), .INCLUSIVE(INCLUSIVE)) u_cmp_y (
    .x(in_y), .lo(thr_eff[4]), .hi(thr_eff[5]), .in_range(y_in_range));
`else
  logic [DATA_W-1:0] y_p1_q, y_p1_d;
  logic              unused_y;
  assign thr_in   = {thr_td, thr_tc, thr_tb, thr_ta};
  assign unused_y = ^y_p1_q;
`endif

  // A frame-start beat promotes shadow to active and classifies with the promoted set;
  // a write landing on that same beat bypasses the shadow so it takes effect immediately.
  always_comb begin
    shadow_d = thr_wr ? thr_in : shadow_q;
    thr_eff  = active_q;
    if (in_valid && in_sof) thr_eff = thr_wr ? thr_in : shadow_q;
    active_d = thr_eff;
  end

  skin_range_cmp #(.DATA_W(DATA_W), .INCLUSIVE(INCLUSIVE)) u_cmp_cb (
    .x(in_cb), .lo(thr_eff[0]), .hi(thr_eff[1]), .in_range(cb_in_range));
  skin_range_cmp #(.DATA_W(DATA_W), .INCLUSIVE(INCLUSIVE)) u_cmp_cr (
    .x(in_cr), .lo(thr_eff[2]), .hi(thr_eff[3]), .in_range(cr_in_range));

  // S1: window compares
  always_comb begin
    vld_p1_d   = in_valid;
    sof_p1_d   = in_valid & in_sof;
    cb_ok_p1_d = cb_in_range;
    cr_ok_p1_d = cr_in_range;
`ifdef SKIN_Y_GATE_EN
    y_ok_p1_d  = y_in_range;
    skin_p1    = cb_ok_p1_q & cr_ok_p1_q & y_ok_p1_q;
`else
    y_p1_d     = in_y;
    skin_p1    = cb_ok_p1_q & cr_ok_p1_q;
`endif
  end

  // S2: mask and frame counter, both advanced by the beat leaving S1
  always_comb begin
    vld_p2_d    = vld_p1_q;
    sof_p2_d    = sof_p1_q;
    mask_p2_d   = mask_p2_q;
    run_cnt_d   = run_cnt_q;
    frame_cnt_d = frame_cnt_q;
    cnt_vld_d   = 1'b0;
    if (vld_p1_q) begin
      mask_p2_d = skin_p1 ? {MASK_W{MASK_ON}} : {MASK_W{MASK_OFF}};
      if (sof_p1_q) begin
        frame_cnt_d = run_cnt_q;
        cnt_vld_d   = 1'b1;
        run_cnt_d   = skin_p1 ? CNT_W'(1) : '0;
      end else if (skin_p1) begin
        run_cnt_d = sat_inc(run_cnt_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q    <= THR_RST;
      active_q    <= THR_RST;
      vld_p1_q    <= 1'b0;
      sof_p1_q    <= 1'b0;
      cb_ok_p1_q  <= 1'b0;
      cr_ok_p1_q  <= 1'b0;
`ifdef SKIN_Y_GATE_EN
      y_ok_p1_q   <= 1'b0;
`else
      y_p1_q      <= '0;
`endif
      vld_p2_q    <= 1'b0;
      sof_p2_q    <= 1'b0;
      mask_p2_q   <= '0;
      run_cnt_q   <= '0;
      frame_cnt_q <= '0;
      cnt_vld_q   <= 1'b0;
    end else begin
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      vld_p1_q    <= vld_p1_d;
      sof_p1_q    <= sof_p1_d;
      cb_ok_p1_q  <= cb_ok_p1_d;
      cr_ok_p1_q  <= cr_ok_p1_d;
`ifdef SKIN_Y_GATE_EN
      y_ok_p1_q   <= y_ok_p1_d;
`else
      y_p1_q      <= y_p1_d;
`endif
      vld_p2_q    <= vld_p2_d;
      sof_p2_q    <= sof_p2_d;
      mask_p2_q   <= mask_p2_d;
      run_cnt_q   <= run_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      cnt_vld_q   <= cnt_vld_d;
    end
  end

  assign out_valid = vld_p2_q;
  assign out_sof   = sof_p2_q;
  assign out_mask  = mask_p2_q;
  assign frame_cnt = frame_cnt_q;
  assign cnt_valid = cnt_vld_q;
endmodule

// File: tb/tb_skin_threshold_stream.sv
// Scoreboard bench: three instances (strict, inclusive, 3-bit counter) share one stimulus stream;
// expected masks and frame counts are queued at issue time and popped by a monitor on output beats.
module tb_skin_threshold_stream;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0, in_sof = 1'b0;
  logic [7:0] in_y = 8'd128, in_cb = 8'd0, in_cr = 8'd0;
  logic       thr_wr = 1'b0;
  logic [7:0] thr_ta = 8'd77, thr_tb = 8'd127, thr_tc = 8'd133, thr_td = 8'd173;
  logic [7:0] thr_ylo = 8'd0, thr_yhi = 8'd255;

  logic        ov_def, os_def, cv_def;
  logic [7:0]  om_def;
  logic [19:0] fc_def;
  logic        ov_inc, os_inc, unused_cv_inc;
  logic [7:0]  om_inc;
  logic [19:0] unused_fc_inc;
  logic        ov_sat, os_sat, cv_sat;
  logic [7:0]  om_sat;
  logic [2:0]  fc_sat;

  typedef struct packed {
    logic       sof;
    logic [7:0] m_def;
    logic [7:0] m_inc;
  } exp_t;

  exp_t        q_mask[$];
  logic [19:0] q_cnt[$];
  logic [2:0]  q_sat[$];
  exp_t        mon_e;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  skin_threshold_stream dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
    .in_y(in_y), .in_cb(in_cb), .in_cr(in_cr), .thr_wr(thr_wr),
    .thr_ta(thr_ta), .thr_tb(thr_tb), .thr_tc(thr_tc), .thr_td(thr_td),
`ifdef SKIN_Y_GATE_EN
    .thr_ylo(thr_ylo), .thr_yhi(thr_yhi),
`endif
    .out_valid(ov_def), .out_sof(os_def), .out_mask(om_def),
    .frame_cnt(fc_def), .cnt_valid(cv_def));

  skin_threshold_stream #(.INCLUSIVE(1)) dut_inc (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
    .in_y(in_y), .in_cb(in_cb), .in_cr(in_cr), .thr_wr(thr_wr),
    .thr_ta(thr_ta), .thr_tb(thr_tb), .thr_tc(thr_tc), .thr_td(thr_td),
`ifdef SKIN_Y_GATE_EN
    .thr_ylo(thr_ylo), .thr_yhi(thr_yhi),
`endif
    .out_valid(ov_inc), .out_sof(os_inc), .out_mask(om_inc),
    .frame_cnt(unused_fc_inc), .cnt_valid(unused_cv_inc));

  skin_threshold_stream #(.CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
    .in_y(in_y), .in_cb(in_cb), .in_cr(in_cr), .thr_wr(thr_wr),
    .thr_ta(thr_ta), .thr_tb(thr_tb), .thr_tc(thr_tc), .thr_td(thr_td),
`ifdef SKIN_Y_GATE_EN
    .thr_ylo(thr_ylo), .thr_yhi(thr_yhi),
`endif
    .out_valid(ov_sat), .out_sof(os_sat), .out_mask(om_sat),
    .frame_cnt(fc_sat), .cnt_valid(cv_sat));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One valid beat; the expected mask is queued, and for sof beats the expected
  // count of the frame that just closed is queued as well.
  task automatic beat(input logic sof, input logic [7:0] y, input logic [7:0] cb,
                      input logic [7:0] cr, input logic [7:0] e_def, input logic [7:0] e_inc,
                      input logic [19:0] e_cnt, input logic [2:0] e_sat);
    exp_t e;
    e.sof = sof; e.m_def = e_def; e.m_inc = e_inc;
    q_mask.push_back(e);
    if (sof) begin
      q_cnt.push_back(e_cnt);
      q_sat.push_back(e_sat);
    end
    in_valid = 1'b1; in_sof = sof; in_y = y; in_cb = cb; in_cr = cr;
    @(posedge clk); #1;
    in_valid = 1'b0; in_sof = 1'b0; thr_wr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (ov_def || ov_inc || ov_sat) begin
        check("valid_align", {29'd0, ov_def, ov_inc, ov_sat}, 32'd7);
        if (q_mask.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat: out_valid=1 with no beat outstanding");
        end else begin
          mon_e = q_mask.pop_front();
          check("mask_strict", {24'd0, om_def}, {24'd0, mon_e.m_def});
          check("mask_incl", {24'd0, om_inc}, {24'd0, mon_e.m_inc});
          check("mask_sat", {24'd0, om_sat}, {24'd0, mon_e.m_def});
          check("out_sof", {31'd0, os_def}, {31'd0, mon_e.sof});
          check("out_sof_incl", {31'd0, os_inc}, {31'd0, mon_e.sof});
          check("out_sof_sat", {31'd0, os_sat}, {31'd0, mon_e.sof});
        end
      end
      if (cv_def) begin
        if (q_cnt.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_cnt_valid: frame_cnt=%0d with none expected", fc_def);
        end else check("frame_cnt", {12'd0, fc_def}, {12'd0, q_cnt.pop_front()});
      end
      if (cv_sat) begin
        if (q_sat.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_cnt_valid_sat: frame_cnt=%0d with none expected", fc_sat);
        end else check("frame_cnt_sat", {29'd0, fc_sat}, {29'd0, q_sat.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] pat;
    pat = 11'b10001010010;
    idle(3);
    check("rst_out_valid", {31'd0, ov_def}, 32'd0);
    check("rst_out_mask", {24'd0, om_def}, 32'd0);
    check("rst_frame_cnt", {12'd0, fc_def}, 32'd0);
    check("rst_cnt_valid", {31'd0, cv_def}, 32'd0);
    rst = 1'b0;
    idle(1);

    // Default window, strict vs inclusive edges
    beat(1, 128, 100, 150, 8'hFF, 8'hFF, 20'd0, 3'd0);
    beat(0, 128,  77, 150, 8'h00, 8'hFF, 20'd0, 3'd0);
    beat(0, 128, 127, 150, 8'h00, 8'hFF, 20'd0, 3'd0);
    beat(0, 128, 100, 173, 8'h00, 8'hFF, 20'd0, 3'd0);
    beat(0, 128, 100, 174, 8'h00, 8'h00, 20'd0, 3'd0);
    idle(2);

    // Mid-frame shadow write must not disturb the current frame
    thr_ta = 8'd10; thr_tb = 8'd20; thr_wr = 1'b1;
    idle(1);
    thr_wr = 1'b0;
    beat(0, 128, 100, 150, 8'hFF, 8'hFF, 20'd0, 3'd0);
    beat(0, 128,  15, 150, 8'h00, 8'h00, 20'd0, 3'd0);
    beat(1, 128,  15, 150, 8'hFF, 8'hFF, 20'd2, 3'd2);
    beat(0, 128, 100, 150, 8'h00, 8'h00, 20'd0, 3'd0);
    // Write coinciding with sof is used on that very beat
    thr_ta = 8'd77; thr_tb = 8'd127; thr_wr = 1'b1;
    beat(1, 128, 100, 150, 8'hFF, 8'hFF, 20'd1, 3'd1);

    // 12-beat frame (sof beat above + 11) with 5 skin, random gaps
    for (int i = 0; i < 11; i++) begin
      if (pat[i]) beat(0, 128, 100, 150, 8'hFF, 8'hFF, 20'd0, 3'd0);
      else        beat(0, 128,  50, 150, 8'h00, 8'h00, 20'd0, 3'd0);
      idle($urandom_range(0, 2));
    end
    beat(1, 128, 100, 150, 8'hFF, 8'hFF, 20'd5, 3'd5);

    // 10 skin beats: full-width counter reads 10, 3-bit counter saturates at 7
    for (int i = 0; i < 9; i++) beat(0, 128, 100, 150, 8'hFF, 8'hFF, 20'd0, 3'd0);
    beat(1, 128, 50, 150, 8'h00, 8'h00, 20'd10, 3'd7);
    beat(0, 128, 100, 150, 8'hFF, 8'hFF, 20'd0, 3'd0);
    beat(0, 128, 100, 150, 8'hFF, 8'hFF, 20'd0, 3'd0);
    idle(3);

    // Reset mid-frame with one beat in flight
    in_valid = 1'b1; in_sof = 1'b0; in_cb = 8'd100; in_cr = 8'd150;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_out_valid", {31'd0, ov_def}, 32'd0);
    check("midrst_out_sof", {31'd0, os_def}, 32'd0);
    check("midrst_out_mask", {24'd0, om_def}, 32'd0);
    check("midrst_frame_cnt", {12'd0, fc_def}, 32'd0);
    check("midrst_frame_cnt_sat", {29'd0, fc_sat}, 32'd0);
    check("midrst_cnt_valid", {31'd0, cv_def}, 32'd0);
    rst = 1'b0; in_valid = 1'b0;
    idle(2);
    beat(1, 128, 100, 150, 8'hFF, 8'hFF, 20'd0, 3'd0);
    beat(0, 128, 100, 150, 8'hFF, 8'hFF, 20'd0, 3'd0);
    beat(1, 128,  50, 150, 8'h00, 8'h00, 20'd2, 3'd2);

`ifdef SKIN_Y_GATE_EN
    thr_ylo = 8'd50; thr_yhi = 8'd200; thr_wr = 1'b1;
    beat(1,  30, 100, 150, 8'h00, 8'h00, 20'd0, 3'd0);
    beat(0, 100, 100, 150, 8'hFF, 8'hFF, 20'd0, 3'd0);
    beat(0, 220, 100, 150, 8'h00, 8'h00, 20'd0, 3'd0);
`endif

    idle(6);
    check("drain_masks", q_mask.size(), 32'd0);
    check("drain_cnt", q_cnt.size(), 32'd0);
    check("drain_cnt_sat", q_sat.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
